xillybus_seekable_regfile_16: RTL and testbench

//  User-side responder for one 16-bit seekable Xillybus stream pair (write + read sharing one address).

---
 rtl/xillybus_seekable_regfile_16.sv | 164 ++++++++++++++++
 tb/tb_xillybus_seekable_regfile_16.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_seekable_regfile_16.sv
// ---------------------------------------------------------------------------
// xillybus_seekable_regfile_16
//
// User-side responder for one 16-bit seekable Xillybus stream pair. The write
// stream and the read stream share one seek address. Words written by the
// host land in a register file. Host reads return those words. The register
// file is exported flat, so the acquisition logic can use it as a control
// register bank.
//
// Ports (all logic runs on the rising edge of bus_clk_i):
//   bus_clk_i        Xillybus user clock
//   reset_i          asynchronous, active-high reset
//   w_wren_i         host write strobe, w_data_i accepted this cycle
//   w_data_i         host write data
//   w_full_o         always 0, writes never stall
//   w_open_i         write file open (informational only)
//   r_rden_i         host read strobe, data valid the next cycle
//   r_data_o         registered read data
//   r_empty_o        no readable word at the read pointer
//   r_eof_o          end-of-file to host (empty while the read file is open)
//   r_open_i         read file open
//   addr_i           seek address from the Xillybus core
//   addr_update_i    one-cycle pulse that loads addr_i into both pointers
//   regs_flat_o      all registers, register k at [16k+15:16k]
//   reg_wr_strobe_o  bit k pulses for one cycle after register k is written
// ---------------------------------------------------------------------------
module xillybus_seekable_regfile_16 #(
  parameter int          NREGS     = 32,
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic                  bus_clk_i,
  input  logic                  reset_i,
  input  logic                  w_wren_i,
  input  logic [15:0]           w_data_i,
  output logic                  w_full_o,
  input  logic                  w_open_i,
  input  logic                  r_rden_i,
  output logic [15:0]           r_data_o,
  output logic                  r_empty_o,
  output logic                  r_eof_o,
  input  logic                  r_open_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  addr_update_i,
  output logic [NREGS*16-1:0]   regs_flat_o,
  output logic [NREGS-1:0]      reg_wr_strobe_o
);

  // Index width into the register file. It is at least one bit, so a
  // single-register build still has a legal index.
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  // A pointer parks at this value and does not wrap back into the register
  // file. A long stream past the end therefore cannot silently overwrite
  // register 0.
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [15:0]       regs_q [NREGS];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [15:0]       rData_q, rData_d;
  logic [NREGS-1:0]  wrStrobe_q, wrStrobe_d;

  logic [ADDR_W-1:0] wrTarget;
  logic [ADDR_W-1:0] rdAddr;
  logic              wrHit;
  logic              rdHit;
  logic [IDX_W-1:0]  wrIdx;
  logic [IDX_W-1:0]  rdIdx;

  // True when an address falls inside the register file. The compare is done
  // at 32 bits, so NREGS never gets truncated to the pointer width.
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NREGS);
  endfunction

  // Increment a pointer. The result saturates at the all-ones address.
  function automatic logic [ADDR_W-1:0] satInc(input logic [ADDR_W-1:0] a);
    return (a == PTR_MAX) ? a : a + ADDR_W'(1);
  endfunction

  // Write side. A seek pulse in the same cycle as a write redirects that
  // write to the new address. Out-of-range words are dropped, but they
  // still advance the pointer. The host then sees a normal stream that
  // simply stops storing data.
  always_comb begin
    wrTarget   = addr_update_i ? addr_i : wrPtr_q;
    wrHit      = w_wren_i && inRange(wrTarget);
    wrIdx      = wrTarget[IDX_W-1:0];
    wrPtr_d    = wrTarget;
    wrStrobe_d = '0;
    if (w_wren_i) begin
      wrPtr_d = satInc(wrTarget);
    end
    if (wrHit) begin
      wrStrobe_d[wrIdx] = 1'b1;
    end
  end

  // Read side. A seek pulse in the same cycle as a read redirects that read.
  // A read strobe while empty is a host protocol violation. It returns zero
  // and leaves the pointer in place. The data comes from the register state
  // before this edge, so a read that collides with a write to the same index
  // returns the old value.
  always_comb begin
    rdAddr  = addr_update_i ? addr_i : rdPtr_q;
    rdHit   = r_rden_i && inRange(rdAddr);
    rdIdx   = rdAddr[IDX_W-1:0];
    rdPtr_d = rdAddr;
    rData_d = rData_q;
    if (rdHit) begin
      rdPtr_d = satInc(rdAddr);
      rData_d = regs_q[rdIdx];
    end else if (r_rden_i) begin
      rData_d = 16'h0000;
    end
  end

  // Register file storage. Reset returns every register to RESET_VAL at
  // once, even in the middle of a host burst.
  always_ff @(posedge bus_clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else if (wrHit) begin
      regs_q[wrIdx] <= w_data_i;
    end
  end

  // Pointers, read data and the write strobe. A read still in flight when
  // reset arrives is discarded.
  always_ff @(posedge bus_clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      rData_q    <= 16'h0000;
      wrStrobe_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      rData_q    <= rData_d;
      wrStrobe_q <= wrStrobe_d;
    end
  end

  // Flatten the register file for the acquisition logic.
  for (genvar g = 0; g < NREGS; g++) begin : gFlat
    assign regs_flat_o[16*g +: 16] = regs_q[g];
  end

  // Opening or closing a file leaves all state alone, because the host
  // re-seeks after every open. Only the read side needs r_open_i, to
  // qualify EOF.
  logic unusedWOpen;
  assign unusedWOpen = w_open_i;

  assign w_full_o        = 1'b0;
  assign r_data_o        = rData_q;
  assign r_empty_o       = !inRange(rdPtr_q);
  assign r_eof_o         = r_empty_o && r_open_i;
  assign reg_wr_strobe_o = wrStrobe_q;

endmodule

// File: tb/tb_xillybus_seekable_regfile_16.sv
module tb_xillybus_seekable_regfile_16;

  localparam int          NREGS     = 32;
  localparam logic [15:0] RESET_VAL = 16'h0000;

  logic                clk = 1'b0;
  logic                reset;
  logic                wWren;
  logic [15:0]         wData;
  logic                wFull;
  logic                wOpen;
  logic                rRden;
  logic [15:0]         rData;
  logic                rEmpty;
  logic                rEof;
  logic                rOpen;
  logic [15:0]         addr;
  logic                addrUpdate;
  logic [NREGS*16-1:0] regsFlat;
  logic [NREGS-1:0]    regWrStrobe;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  logic [15:0] mRegs [NREGS];
  logic [15:0] mWrPtr;
  logic [15:0] mRdPtr;
  logic [31:0] mStrobe;
  logic [15:0] sbQueue [$];

  xillybus_seekable_regfile_16 #(
    .NREGS(NREGS), .ADDR_W(16), .RESET_VAL(RESET_VAL)
  ) dut (
    .bus_clk_i(clk), .reset_i(reset),
    .w_wren_i(wWren), .w_data_i(wData), .w_full_o(wFull), .w_open_i(wOpen),
    .r_rden_i(rRden), .r_data_o(rData), .r_empty_o(rEmpty), .r_eof_o(rEof),
    .r_open_i(rOpen), .addr_i(addr), .addr_update_i(addrUpdate),
    .regs_flat_o(regsFlat), .reg_wr_strobe_o(regWrStrobe)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] getReg(input int k);
    return regsFlat[16*k +: 16];
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < NREGS; k++) mRegs[k] = RESET_VAL;
    mWrPtr  = 16'd0;
    mRdPtr  = 16'd0;
    mStrobe = 32'd0;
    sbQueue.delete();
  endtask

  task automatic checkRegs(input string tag);
    for (int k = 0; k < NREGS; k++)
      checkOutput($sformatf("%s_reg%0d", tag, k), {16'd0, getReg(k)}, {16'd0, mRegs[k]});
  endtask

  // Drive one clock cycle of host activity. The model is updated and the
  // expected read data is queued. After the edge, the strobe and any
  // completed read are checked.
  task automatic applyStimulus(input logic au, input logic [15:0] a, input logic we,
                               input logic [15:0] wd, input logic re);
    logic [15:0] rdA;
    logic [15:0] wrT;
    logic [15:0] expData;
    addrUpdate = au; addr = a; wWren = we; wData = wd; rRden = re;
    // read model first: read-before-write on collisions
    rdA = au ? a : mRdPtr;
    if (re) begin
      if (rdA < NREGS) begin
        sbQueue.push_back(mRegs[rdA[4:0]]);
        mRdPtr = satInc(rdA);
      end else begin
        sbQueue.push_back(16'h0000);
        mRdPtr = rdA;
      end
    end else begin
      mRdPtr = rdA;
    end
    wrT = au ? a : mWrPtr;
    mStrobe = 32'd0;
    if (we) begin
      if (wrT < NREGS) begin
        mRegs[wrT[4:0]] = wd;
        mStrobe[wrT[4:0]] = 1'b1;
      end
      mWrPtr = satInc(wrT);
    end else begin
      mWrPtr = wrT;
    end
    @(posedge clk);
    #1;
    addrUpdate = 1'b0; wWren = 1'b0; rRden = 1'b0;
    checkOutput("reg_wr_strobe", regWrStrobe, mStrobe);
    if (re) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        expData = sbQueue.pop_front();
        checkOutput("r_data", {16'd0, rData}, {16'd0, expData});
      end
    end
  endtask

  initial begin
    reset = 1'b1; wWren = 1'b0; wData = 16'h0; wOpen = 1'b1; rRden = 1'b0;
    rOpen = 1'b1; addr = 16'h0; addrUpdate = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    checkRegs("rst");
    checkOutput("rst_r_data", {16'd0, rData}, 32'd0);
    checkOutput("rst_strobe", regWrStrobe, 32'd0);
    checkOutput("rst_w_full", {31'd0, wFull}, 32'd0);
    checkOutput("rst_r_empty", {31'd0, rEmpty}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: seek to 4, three writes
    applyStimulus(1'b1, 16'd4, 1'b1, 16'h00A1, 1'b0);
    checkOutput("t1_reg4", {16'd0, getReg(4)}, 32'h00A1);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'h00B2, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'h00C3, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b0);
    checkRegs("t1");

    // 2: seek to 5, two reads
    applyStimulus(1'b1, 16'd5, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t2_r_data0", {16'd0, rData}, 32'h00B2);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t2_r_data1", {16'd0, rData}, 32'h00C3);
    checkOutput("t2_r_empty", {31'd0, rEmpty}, 32'd0);

    // 3: last register, then empty / eof
    applyStimulus(1'b1, 16'd31, 1'b0, 16'h0000, 1'b1);
    checkOutput("t3_r_empty", {31'd0, rEmpty}, 32'd1);
    checkOutput("t3_r_eof_open", {31'd0, rEof}, 32'd1);
    rOpen = 1'b0; #1;
    checkOutput("t3_r_eof_closed", {31'd0, rEof}, 32'd0);
    rOpen = 1'b1;

    // 4: write past the end, second word dropped
    applyStimulus(1'b1, 16'd31, 1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'h2222, 1'b0);
    checkOutput("t4_reg31", {16'd0, getReg(31)}, 32'h1111);
    checkRegs("t4");
    // read last word, then a read while empty returns zero
    applyStimulus(1'b1, 16'd31, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t4_r_empty_hold", {31'd0, rEmpty}, 32'd1);
    // saturating pointer: writes near the top of the address space are dropped
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 16'hDEAD, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'hBEEF, 1'b0);
    checkRegs("t4_sat");

    // 5: collision at reg2, read returns the old value
    applyStimulus(1'b1, 16'd2, 1'b1, 16'h1234, 1'b0);
    applyStimulus(1'b1, 16'd2, 1'b1, 16'h5A5A, 1'b1);
    checkOutput("t5_reg2", {16'd0, getReg(2)}, 32'h5A5A);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'h7777, 1'b0);
    checkOutput("t5_reg3_wrptr", {16'd0, getReg(3)}, 32'h7777);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t5_rdptr3", {16'd0, rData}, 32'h7777);

    // 6: reset mid-burst, with a read in flight
    applyStimulus(1'b1, 16'd0, 1'b1, 16'h0101, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'h0202, 1'b0);
    wWren = 1'b1; wData = 16'h0303; rRden = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    wWren = 1'b0; rRden = 1'b0;
    resetModel();
    checkRegs("t6");
    checkOutput("t6_r_data", {16'd0, rData}, 32'd0);
    checkOutput("t6_strobe", regWrStrobe, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 16'd0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t6_post_read", {16'd0, rData}, {16'd0, RESET_VAL});
    checkOutput("t6_sb_empty", sbQueue.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
